// File: rtl/tdm_demux_1_4.sv
// Time-division 1-to-4 demultiplexer: steers a sync-framed serial word stream
// into four registered lanes, flagging lane writes, completed frames and early syncs.
module tdm_demux_1_4 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic [3:0]       y_valid,
  output logic             frame_valid,
  output logic             sync_err,
  output logic             sel_A,
  output logic             sel_B
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state_q;
  logic [1:0]       slot_q;
  logic [WIDTH-1:0] lane_q [4];
  logic [3:0]       y_valid_q;
  logic             frame_valid_q;
  logic             sync_err_q;

  // Single-process FSM: state, slot counter, lanes and pulses all register together,
  // so every output changes on the same edge as the lane write.
  // NOTE: the lane array is only four words of flops, so it is reset like any other
  // register; a large RAM-style array would normally be left unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      slot_q        <= 2'd0;
      y_valid_q     <= 4'd0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
      for (int i = 0; i < 4; i++) lane_q[i] <= '0;
    end else begin
      // NOTE: pulses default low every cycle with non-blocking assignments; the later
      // assignments below override them within the same edge, never mid-block.
      y_valid_q     <= 4'd0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
      if (din_valid) begin
        unique case (state_q)
          IDLE: begin
            if (frame_sync) begin
              lane_q[0] <= din;
              y_valid_q <= 4'b0001;
              slot_q    <= 2'd1;
              state_q   <= RUN;
            end
          end
          RUN: begin
            if (frame_sync && slot_q != 2'd0) begin
              // Early sync: abandon the partial frame and restart at slot 0.
              sync_err_q <= 1'b1;
              lane_q[0]  <= din;
              y_valid_q  <= 4'b0001;
              slot_q     <= 2'd1;
            end else begin
              lane_q[slot_q] <= din;
              y_valid_q      <= 4'b0001 << slot_q;
              frame_valid_q  <= (slot_q == 2'd3);
              slot_q         <= slot_q + 2'd1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign y0          = lane_q[0];
  assign y1          = lane_q[1];
  assign y2          = lane_q[2];
  assign y3          = lane_q[3];
  assign y_valid     = y_valid_q;
  assign frame_valid = frame_valid_q;
  assign sync_err    = sync_err_q;
  assign sel_A       = slot_q[1];
  assign sel_B       = slot_q[0];

endmodule

// File: tb/tb_tdm_demux_1_4.sv
// Self-checking bench for tdm_demux_1_4: directed vector table, asynchronous reset
// sequence, and randomized traffic against a frame-level reference model.
module tb_tdm_demux_1_4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din = 8'h00;
  logic       din_valid = 1'b0;
  logic       frame_sync = 1'b0;
  logic [7:0] y0, y1, y2, y3;
  logic [3:0] y_valid;
  logic       frame_valid, sync_err, sel_A, sel_B;

  int checks = 0;
  int errors = 0;

  tdm_demux_1_4 #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .y0         (y0),
    .y1         (y1),
    .y2         (y2),
    .y3         (y3),
    .y_valid    (y_valid),
    .frame_valid(frame_valid),
    .sync_err   (sync_err),
    .sel_A      (sel_A),
    .sel_B      (sel_B)
  );

  always #5 clk = ~clk;

  // Expected outputs packed as {y3,y2,y1,y0, y_valid, frame_valid, sync_err, slot}.
  typedef struct {
    logic [7:0]  din;
    logic        v;
    logic        s;
    logic [31:0] y;
    logic [3:0]  yv;
    logic        fv;
    logic        se;
    logic [1:0]  slot;
  } vec_t;

  vec_t tbl [20];

  // Reference model: frame-level view (locked flag, next slot number, four lanes).
  bit         m_locked;
  int         m_slot;
  logic [7:0] m_lane [4];
  logic [3:0] m_yv;
  logic       m_fv, m_se;

  function automatic vec_t mk(input logic [7:0] d, input logic v, input logic s,
                              input logic [31:0] y, input logic [3:0] yv,
                              input logic fv, input logic se, input logic [1:0] slot);
    vec_t r;
    r.din = d; r.v = v; r.s = s; r.y = y; r.yv = yv; r.fv = fv; r.se = se; r.slot = slot;
    return r;
  endfunction

  function automatic logic [39:0] dut_outs();
    return {y3, y2, y1, y0, y_valid, frame_valid, sync_err, sel_A, sel_B};
  endfunction

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got y=%h yv=%b fv=%b se=%b slot=%b, want y=%h yv=%b fv=%b se=%b slot=%b",
               name, act[39:8], act[7:4], act[3], act[2], act[1:0],
               exp[39:8], exp[7:4], exp[3], exp[2], exp[1:0]);
    end
  endtask

  task automatic model_reset();
    m_locked = 1'b0;
    m_slot   = 0;
    for (int i = 0; i < 4; i++) m_lane[i] = 8'h00;
    m_yv = 4'd0; m_fv = 1'b0; m_se = 1'b0;
  endtask

  task automatic model_step(input logic [7:0] d, input logic v, input logic s);
    m_yv = 4'd0; m_fv = 1'b0; m_se = 1'b0;
    if (!v) return;
    if (!m_locked) begin
      if (s) begin
        m_lane[0] = d; m_yv[0] = 1'b1; m_slot = 1; m_locked = 1'b1;
      end
    end else if (s && m_slot != 0) begin
      m_se = 1'b1; m_lane[0] = d; m_yv[0] = 1'b1; m_slot = 1;
    end else begin
      m_lane[m_slot] = d;
      m_yv[m_slot]   = 1'b1;
      m_fv           = (m_slot == 3);
      m_slot         = (m_slot + 1) % 4;
    end
  endtask

  function automatic logic [39:0] model_outs();
    logic [1:0] sl;
    sl = 2'(m_slot);
    return {m_lane[3], m_lane[2], m_lane[1], m_lane[0], m_yv, m_fv, m_se, sl};
  endfunction

  // Drive on the falling edge, sample 1 ns after the rising edge.
  task automatic drive(input logic [7:0] d, input logic v, input logic s);
    @(negedge clk);
    din = d; din_valid = v; frame_sync = s;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; din_valid = 1'b0; frame_sync = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    tbl[0]  = mk(8'h11, 1, 0, 32'h00000000, 4'b0000, 0, 0, 2'd0);
    tbl[1]  = mk(8'h22, 1, 0, 32'h00000000, 4'b0000, 0, 0, 2'd0);
    tbl[2]  = mk(8'hA0, 1, 1, 32'h000000A0, 4'b0001, 0, 0, 2'd1);
    tbl[3]  = mk(8'hA1, 1, 0, 32'h0000A1A0, 4'b0010, 0, 0, 2'd2);
    tbl[4]  = mk(8'hA2, 1, 0, 32'h00A2A1A0, 4'b0100, 0, 0, 2'd3);
    tbl[5]  = mk(8'hA3, 1, 0, 32'hA3A2A1A0, 4'b1000, 1, 0, 2'd0);
    tbl[6]  = mk(8'hEE, 0, 0, 32'hA3A2A1A0, 4'b0000, 0, 0, 2'd0);
    tbl[7]  = mk(8'hB0, 1, 0, 32'hA3A2A1B0, 4'b0001, 0, 0, 2'd1);
    tbl[8]  = mk(8'hEE, 0, 0, 32'hA3A2A1B0, 4'b0000, 0, 0, 2'd1);
    tbl[9]  = mk(8'hB1, 1, 0, 32'hA3A2B1B0, 4'b0010, 0, 0, 2'd2);
    tbl[10] = mk(8'hB2, 1, 0, 32'hA3B2B1B0, 4'b0100, 0, 0, 2'd3);
    tbl[11] = mk(8'hEE, 0, 0, 32'hA3B2B1B0, 4'b0000, 0, 0, 2'd3);
    tbl[12] = mk(8'hB3, 1, 0, 32'hB3B2B1B0, 4'b1000, 1, 0, 2'd0);
    tbl[13] = mk(8'hC0, 1, 1, 32'hB3B2B1C0, 4'b0001, 0, 0, 2'd1);
    tbl[14] = mk(8'hC1, 1, 0, 32'hB3B2C1C0, 4'b0010, 0, 0, 2'd2);
    tbl[15] = mk(8'hD0, 1, 1, 32'hB3B2C1D0, 4'b0001, 0, 1, 2'd1);
    tbl[16] = mk(8'hD1, 1, 0, 32'hB3B2D1D0, 4'b0010, 0, 0, 2'd2);
    tbl[17] = mk(8'h77, 0, 1, 32'hB3B2D1D0, 4'b0000, 0, 0, 2'd2);
    tbl[18] = mk(8'hD2, 1, 0, 32'hB3D2D1D0, 4'b0100, 0, 0, 2'd3);
    tbl[19] = mk(8'hD3, 1, 0, 32'hD3D2D1D0, 4'b1000, 1, 0, 2'd0);

    // Reset state.
    #2;
    check("reset_held", dut_outs(), 40'd0);
    do_reset();
    check("reset_released", dut_outs(), 40'd0);

    // Directed vectors.
    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].din, tbl[i].v, tbl[i].s);
      check($sformatf("vec%0d", i), dut_outs(),
            {tbl[i].y, tbl[i].yv, tbl[i].fv, tbl[i].se, tbl[i].slot});
    end

    // Asynchronous reset mid-frame at slot 2, between clock edges.
    drive(8'hE0, 1, 1);
    drive(8'hE1, 1, 0);
    check("pre_async_reset", dut_outs(), {32'hD3D2E1E0, 4'b0010, 1'b0, 1'b0, 2'd2});
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_immediate", dut_outs(), 40'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(8'h55, 1, 0);
    check("post_reset_drop0", dut_outs(), 40'd0);
    drive(8'h66, 1, 0);
    check("post_reset_drop1", dut_outs(), 40'd0);
    drive(8'h99, 1, 1);
    check("post_reset_relock", dut_outs(), {32'h00000099, 4'b0001, 1'b0, 1'b0, 2'd1});

    // Randomized traffic against the reference model.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      logic [7:0] d;
      logic       v, s;
      d = 8'($urandom);
      v = ($urandom_range(3, 0) != 0);
      s = ($urandom_range(5, 0) == 0);
      drive(d, v, s);
      model_step(d, v, s);
      check($sformatf("rand%0d", n), dut_outs(), model_outs());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
